uart_receive: RTL and testbench
===============================

// Module: uart_receive
// PURPOSE
//  Serial-to-parallel UART receiver: 8N1 frames on rx, one data byte out per frame.
//  Companion to the board's transmitter; uses the same bit timing.
//  Sits between the FPGA rx pin and display-control logic; needs no ready/accept handshake.
// PARAMETERS
//  BAUD_RATE        9600  line rate, bits/s
//  CLOCK_SPEED_MHZ  100   clk frequency, MHz
//  CYCLES_WAIT      CLOCK_SPEED_MHZ*1e6/BAUD_RATE, integer, truncated (derived, not overridden)
// PORTS
//  clk             in   1  system clock, all logic on posedge
//  rst             in   1  asynchronous, active-high reset
//  rx              in   1  serial line, idle high, asynchronous to clk
//  data_byte       out  8  last correctly received byte, LSB = first data bit
//  data_valid      out  1  1-clk pulse: data_byte just updated
//  framing_error   out  1  1-clk pulse: stop bit sampled low
//  busy            out  1  high whenever state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, data_byte=8'h00, data_valid=0, framing_error=0, busy=0;
//    sync flops=1, counters=0. Reset mid-frame aborts the frame; no pulse is issued.
//  - rx passes through a 2-flop synchronizer (reset value 1). All decisions use the synced value.
//  - Bit period = CYCLES_WAIT+1 clks (counter runs 0..CYCLES_WAIT, then wraps to 0).
//    Counter is 16 bits wide. HALF = CYCLES_WAIT/2 (truncated).
//  - IDLE: synced rx==0 -> START, counter=0.
//  - START: at counter==HALF, sample rx. If 0 -> DATA, counter=0, bit_index=0.
//    If 1 -> glitch: return to IDLE with no pulse.
//  - DATA: at counter==CYCLES_WAIT, shift in rx (LSB first).
//    bit_index 0..7; after bit 7 -> STOP (or PARITY, see CONFIGURATION).
//  - STOP: at counter==CYCLES_WAIT, sample rx.
//    rx==1: data_byte<=shift reg, data_valid=1 for next clk only, state -> IDLE.
//    rx==0: framing_error=1 for 1 clk, data_byte unchanged, state -> BREAK.
//  - BREAK: stay until synced rx==1, then IDLE. This prevents a held-low line
//    from producing repeated frames.
//  - Sampling instants are mid-bit. data_valid rises one clk after the mid-stop sample.
//    Total latency from the start falling edge is approx 9.5 bit periods + 3 clk.
//  - Pulse exclusivity: data_valid and framing_error are never high together.
//  - Back-to-back frames: a start edge seen in IDLE on the clk after STOP is accepted.
//    The receiver returns to IDLE mid-stop-bit, so it tolerates a stop bit shortened
//    by half a bit.
//  - No overrun detection: data_byte holds until the next valid frame overwrites it.
//    The consumer must take the byte on data_valid.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//    - Frame is 8E1. After bit 7 -> PARITY state; rx is sampled at counter==CYCLES_WAIT.
//    - If ^data ^ parity_bit != 0: the byte is discarded at STOP and a parity_error
//      output (1 bit, 1-clk pulse, reset 0) fires instead of data_valid.
//    - A framing error takes precedence over a parity error.
//  UART_RX_PARITY_EN undefined:
//    - 8N1 only. No PARITY state. The parity_error port is absent.
// TESTING  (bench uses CLOCK_SPEED_MHZ=1, BAUD_RATE=100000 -> CYCLES_WAIT=10, 11 clk/bit)
//  1. Reset asserted mid-frame.
//     -> All outputs 0 within the same clk; the next frame 0x3C is received cleanly.
//  2. Frame 0xA5 (start, 1,0,1,0,0,1,0,1 LSB-first, stop=1).
//     -> data_valid pulses once for 1 clk, data_byte=8'hA5, framing_error stays 0.
//  3. Back-to-back frames 0x00 then 0xFF with no idle gap.
//     -> Two data_valid pulses, 11*10 clks apart; data_byte 8'h00 then 8'hFF.
//  4. rx low for 3 clks in IDLE, then high.
//     -> busy rises and then drops at the HALF sample; no data_valid, no framing_error.
//  5. Frame 0x55 with stop bit driven 0, line held low 40 clks, then 0x12 sent.
//     -> framing_error pulse; data_byte stays at its prior value;
//        busy stays high until rx goes high; then data_byte=8'h12.
//  6. Parity build, frame 0x07 with parity bit 0 (wrong under even parity).
//     -> parity_error pulse, no data_valid. Same byte with parity 1 -> data_valid, 8'h07.

Source files
------------

// File: rtl/uart_receive.sv
// uart_receive: 8N1 serial-to-parallel UART receiver, one byte out per frame.
// Latency: about 9.5 bit periods + 3 clk from start edge to data_valid.
// Backpressure: none; data_byte holds until the next good frame, so consume on data_valid.
//
// Ports:
//   clk, rst        system clock (posedge) and asynchronous active-high reset
//   rx              serial line, idle high, asynchronous to clk
//   data_byte       last correctly received byte, LSB = first data bit
//   data_valid      1-clk pulse when data_byte has just been updated
//   framing_error   1-clk pulse when the stop bit is sampled low
//   parity_error    1-clk pulse on even-parity mismatch (UART_RX_PARITY_EN only)
//   busy            high whenever the receiver is not idle
// Optional feature macro: UART_RX_PARITY_EN selects 8E1 framing with parity check.
module uart_receive #(
   parameter int BAUD_RATE       = 9600,
   parameter int CLOCK_SPEED_MHZ = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data_byte,
   output logic       data_valid,
   output logic       framing_error,
`ifdef UART_RX_PARITY_EN
   output logic       parity_error,
`endif
   output logic       busy
);

   localparam int          CW_INT      = CLOCK_SPEED_MHZ * 1000000 / BAUD_RATE;
   localparam logic [15:0] CYCLES_WAIT = 16'(CW_INT);
   localparam logic [15:0] HALF        = 16'(CW_INT / 2);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      BREAK
   } state_t;

   state_t      state, state_n;
   logic        rx_meta, rx_sync;
   logic [15:0] cnt, cnt_n;
   logic [2:0]  idx, idx_n;
   logic [7:0]  shift, shift_n;
   logic [7:0]  byte_n;
   logic        dv_n, fe_n;
`ifdef UART_RX_PARITY_EN
   logic        par_bad, par_bad_n;
   logic        pe_n;
`endif

   // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= 16'd0;
         idx           <= 3'd0;
         shift         <= 8'h00;
         data_byte     <= 8'h00;
         data_valid    <= 1'b0;
         framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad       <= 1'b0;
         parity_error  <= 1'b0;
`endif
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         idx           <= idx_n;
         shift         <= shift_n;
         data_byte     <= byte_n;
         data_valid    <= dv_n;
         framing_error <= fe_n;
`ifdef UART_RX_PARITY_EN
         par_bad       <= par_bad_n;
         parity_error  <= pe_n;
`endif
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      idx_n     = idx;
      shift_n   = shift;
      byte_n    = data_byte;
      dv_n      = 1'b0;
      fe_n      = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_n = par_bad;
      pe_n      = 1'b0;
`endif
      case (state)
         IDLE: begin
            cnt_n = 16'd0;
            if (!rx_sync) state_n = START;
         end
         START: begin
            // Re-check mid start bit so short glitches are rejected.
            if (cnt == HALF) begin
               cnt_n   = 16'd0;
               idx_n   = 3'd0;
               state_n = rx_sync ? IDLE : DATA;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         DATA: begin
            if (cnt == CYCLES_WAIT) begin
               cnt_n   = 16'd0;
               shift_n = {rx_sync, shift[7:1]};
               if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end else begin
                  idx_n = idx + 3'd1;
               end
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt == CYCLES_WAIT) begin
               cnt_n     = 16'd0;
               par_bad_n = (^shift) ^ rx_sync;
               state_n   = STOP;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
`endif
         STOP: begin
            // Leaves mid stop bit, so the next start edge is caught even with a short stop.
            if (cnt == CYCLES_WAIT) begin
               cnt_n = 16'd0;
               if (rx_sync) begin
                  state_n = IDLE;
`ifdef UART_RX_PARITY_EN
                  if (par_bad) begin
                     pe_n = 1'b1;
                  end else begin
                     dv_n   = 1'b1;
                     byte_n = shift;
                  end
`else
                  dv_n   = 1'b1;
                  byte_n = shift;
`endif
               end else begin
                  fe_n    = 1'b1;
                  state_n = BREAK;
               end
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         BREAK: begin
            // Wait out a held-low line so it cannot be decoded as a stream of frames.
            cnt_n = 16'd0;
            if (rx_sync) state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
            cnt_n   = 16'd0;
         end
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receive.sv
module tb_uart_receive;

   localparam int BIT = 11;   // clocks per bit: CYCLES_WAIT=10 -> 11 clk

   logic       clk;
   logic       rst;
   logic       rx;
   logic [7:0] data_byte;
   logic       data_valid;
   logic       framing_error;
   logic       busy;
`ifdef UART_RX_PARITY_EN
   logic       parity_error;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   // Pulse bookkeeping, sampled on the falling edge.
   int cyc       = 0;
   int dv_rise   = 0;
   int dv_hi     = 0;
   int fe_rise   = 0;
   int both_hi   = 0;
   int pe_rise   = 0;
   int dv_last   = 0;
   int dv_prev   = 0;
   logic dv_q = 1'b0, fe_q = 1'b0, pe_q = 1'b0;

   uart_receive #(.BAUD_RATE(100000), .CLOCK_SPEED_MHZ(1)) dut (
      .clk           (clk),
      .rst           (rst),
      .rx            (rx),
      .data_byte     (data_byte),
      .data_valid    (data_valid),
      .framing_error (framing_error),
`ifdef UART_RX_PARITY_EN
      .parity_error  (parity_error),
`endif
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (data_valid) dv_hi = dv_hi + 1;
      if (data_valid && !dv_q) begin
         dv_rise = dv_rise + 1;
         dv_prev = dv_last;
         dv_last = cyc;
      end
      if (framing_error && !fe_q) fe_rise = fe_rise + 1;
      if (data_valid && framing_error) both_hi = both_hi + 1;
`ifdef UART_RX_PARITY_EN
      if (parity_error && !pe_q) pe_rise = pe_rise + 1;
      pe_q = parity_error;
`endif
      dv_q = data_valid;
      fe_q = framing_error;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Sends start, 8 data bits LSB first, optional parity bit, then the stop level.
   // rx is left at the stop level on return.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                             input logic use_par, input logic par);
      rx = 1'b0;
      wait_clk(BIT);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_clk(BIT);
      end
      if (use_par) begin
         rx = par;
         wait_clk(BIT);
      end
      rx = stop_bit;
      wait_clk(BIT);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      rx  = 1'b1;
      wait_clk(3);
      n_cmp++;
      if ({data_byte, data_valid, framing_error, busy} !== 11'h000) begin
         n_fail++;
         $display("FAIL reset_state: got byte=%h dv=%b fe=%b busy=%b, want 00 0 0 0",
                  data_byte, data_valid, framing_error, busy);
      end
      rst = 1'b0;
      wait_clk(5);
   endtask

   task automatic test_reset_mid_frame;
      int dv0, fe0, hi0;
      dv0 = dv_rise; fe0 = fe_rise;
      rx = 1'b0;
      wait_clk(BIT);
      rx = 1'b0;               // bit0 of 0x3C
      wait_clk(BIT + 9);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midframe_busy: got %b want 1", busy);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({data_byte, data_valid, framing_error, busy} !== 11'h000) begin
         n_fail++;
         $display("FAIL midframe_reset_outputs: got byte=%h dv=%b fe=%b busy=%b, want 00 0 0 0",
                  data_byte, data_valid, framing_error, busy);
      end
      rx = 1'b1;
      wait_clk(3);
      rst = 1'b0;
      wait_clk(5);
      dv0 = dv_rise; fe0 = fe_rise; hi0 = dv_hi;
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
      wait_clk(3);
      n_cmp++;
      if (data_byte !== 8'h3C) begin
         n_fail++;
         $display("FAIL after_reset_byte: got %h want 3c", data_byte);
      end
      n_cmp++;
      if ((dv_rise - dv0) !== 1 || (dv_hi - hi0) !== 1 || (fe_rise - fe0) !== 0) begin
         n_fail++;
         $display("FAIL after_reset_pulses: dv=%0d hi=%0d fe=%0d want 1 1 0",
                  dv_rise - dv0, dv_hi - hi0, fe_rise - fe0);
      end
   endtask

   task automatic test_frame_a5;
      int dv0, fe0, hi0;
      dv0 = dv_rise; fe0 = fe_rise; hi0 = dv_hi;
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
      wait_clk(3);
      n_cmp++;
      if (data_byte !== 8'hA5) begin
         n_fail++;
         $display("FAIL a5_byte: got %h want a5", data_byte);
      end
      n_cmp++;
      if ((dv_rise - dv0) !== 1 || (dv_hi - hi0) !== 1) begin
         n_fail++;
         $display("FAIL a5_valid_pulse: rises=%0d high_clks=%0d want 1 1",
                  dv_rise - dv0, dv_hi - hi0);
      end
      n_cmp++;
      if ((fe_rise - fe0) !== 0) begin
         n_fail++;
         $display("FAIL a5_framing: got %0d pulses want 0", fe_rise - fe0);
      end
      wait_clk(5);
   endtask

   task automatic test_back_to_back;
      int dv0;
      logic [7:0] first_byte;
      dv0 = dv_rise;
      send_frame(8'h00, 1'b1, 1'b0, 1'b0);
      // Still inside the stop bit of frame 1; the first pulse is already out.
      first_byte = data_byte;
      send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
      wait_clk(3);
      n_cmp++;
      if (first_byte !== 8'h00) begin
         n_fail++;
         $display("FAIL b2b_first_byte: got %h want 00", first_byte);
      end
      n_cmp++;
      if (data_byte !== 8'hFF) begin
         n_fail++;
         $display("FAIL b2b_second_byte: got %h want ff", data_byte);
      end
      n_cmp++;
      if ((dv_rise - dv0) !== 2) begin
         n_fail++;
         $display("FAIL b2b_pulse_count: got %0d want 2", dv_rise - dv0);
      end
      n_cmp++;
      if ((dv_last - dv_prev) !== 110) begin
         n_fail++;
         $display("FAIL b2b_spacing: got %0d clks want 110", dv_last - dv_prev);
      end
      wait_clk(5);
   endtask

   task automatic test_glitch;
      int dv0, fe0;
      dv0 = dv_rise; fe0 = fe_rise;
      rx = 1'b0;
      wait_clk(3);
      rx = 1'b1;
      wait_clk(2);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL glitch_busy_rise: got %b want 1", busy);
      end
      wait_clk(10);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch_busy_drop: got %b want 0", busy);
      end
      n_cmp++;
      if ((dv_rise - dv0) !== 0 || (fe_rise - fe0) !== 0) begin
         n_fail++;
         $display("FAIL glitch_pulses: dv=%0d fe=%0d want 0 0", dv_rise - dv0, fe_rise - fe0);
      end
      wait_clk(5);
   endtask

   task automatic test_framing;
      int dv0, fe0;
      dv0 = dv_rise; fe0 = fe_rise;
      send_frame(8'h55, 1'b0, 1'b0, 1'b0);   // stop bit low: 11 clks low
      wait_clk(29);                          // 40 clks low in total
      n_cmp++;
      if ((fe_rise - fe0) !== 1 || (dv_rise - dv0) !== 0) begin
         n_fail++;
         $display("FAIL framing_pulses: fe=%0d dv=%0d want 1 0", fe_rise - fe0, dv_rise - dv0);
      end
      n_cmp++;
      if (data_byte !== 8'hFF) begin
         n_fail++;
         $display("FAIL framing_byte_held: got %h want ff", data_byte);
      end
      n_cmp++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL break_busy: got %b want 1", busy);
      end
      rx = 1'b1;
      wait_clk(6);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL break_release: busy got %b want 0", busy);
      end
      send_frame(8'h12, 1'b1, 1'b0, 1'b0);
      wait_clk(3);
      n_cmp++;
      if (data_byte !== 8'h12 || (dv_rise - dv0) !== 1) begin
         n_fail++;
         $display("FAIL after_break_frame: byte=%h dv=%0d want 12 1", data_byte, dv_rise - dv0);
      end
      wait_clk(5);
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity;
      int dv0, pe0;
      logic [7:0] prior;
      prior = data_byte;
      dv0 = dv_rise; pe0 = pe_rise;
      send_frame(8'h07, 1'b1, 1'b1, 1'b0);
      wait_clk(3);
      n_cmp++;
      if ((pe_rise - pe0) !== 1 || (dv_rise - dv0) !== 0 || data_byte !== prior) begin
         n_fail++;
         $display("FAIL parity_bad: pe=%0d dv=%0d byte=%h want 1 0 %h",
                  pe_rise - pe0, dv_rise - dv0, data_byte, prior);
      end
      wait_clk(5);
      dv0 = dv_rise; pe0 = pe_rise;
      send_frame(8'h07, 1'b1, 1'b1, 1'b1);
      wait_clk(3);
      n_cmp++;
      if ((pe_rise - pe0) !== 0 || (dv_rise - dv0) !== 1 || data_byte !== 8'h07) begin
         n_fail++;
         $display("FAIL parity_good: pe=%0d dv=%0d byte=%h want 0 1 07",
                  pe_rise - pe0, dv_rise - dv0, data_byte);
      end
      wait_clk(5);
   endtask
`endif

   initial begin
      rst = 1'b1;
      rx  = 1'b1;
      test_reset();
      test_reset_mid_frame();
      test_frame_a5();
      test_back_to_back();
      test_glitch();
      test_framing();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      n_cmp++;
      if (both_hi !== 0) begin
         n_fail++;
         $display("FAIL pulse_exclusive: overlap clks got %0d want 0", both_hi);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
